// File: rtl/rot_display_pkg.sv
// Shared geometry defaults, derived widths, scanner state encoding and the
// saturating-counter helper used by the rotational display read path.
package rot_display_pkg;

    localparam int ROTATIONAL_RES = 1024;
    localparam int DISPLAY_RADIUS = 32;
    localparam int DISPLAY_HEIGHT = 64;
    localparam int DATA_SIZE      = 1;

    localparam int THETA_W   = $clog2(ROTATIONAL_RES);
    localparam int RADIUS_W  = $clog2(DISPLAY_RADIUS);
    localparam int OVERRUN_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SHIFT   = 2'd2,
        LATCH   = 2'd3
    } scanner_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVERRUN_W-1:0] sat_inc(input logic [OVERRUN_W-1:0] value);
        logic [OVERRUN_W-1:0] result;
        if (value == {OVERRUN_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + OVERRUN_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/column_serializer.sv
// Dual-arm column shifter: loads both columns in parallel and streams them MSB
// first, one bit every SCLK_DIV cycles, with sclk high in the second half.
module column_serializer #(
    parameter int COL_W    = 64,
    parameter int SCLK_DIV = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  load,
    input  logic [1:0][COL_W-1:0] columns,
    output logic [1:0]            sdo,
    output logic                  sclk,
    output logic                  done
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (COL_W > 1) ? $clog2(COL_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(COL_W - 1);

    logic                  active_q;
    logic                  active_d;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      div_d;
    logic [BIT_W-1:0]      bit_q;
    logic [BIT_W-1:0]      bit_d;
    logic [1:0][COL_W-1:0] sh_q;
    logic [1:0][COL_W-1:0] sh_d;
    logic                  sclk_q;
    logic                  sclk_d;

    // Divider, bit counter and shift registers next-state.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        sclk_d   = sclk_q;
        if (load) begin
            sh_d     = columns;
            div_d    = '0;
            bit_d    = '0;
            active_d = 1'b1;
            sclk_d   = 1'b0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                sclk_d   = 1'b0;
                sh_d[0]  = sh_q[0] << 1;
                sh_d[1]  = sh_q[1] << 1;
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                    bit_d    = '0;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end else begin
                div_d  = div_q + DIV_W'(1);
                sclk_d = (div_d >= DIV_HALF);
            end
        end else begin
            sclk_d = 1'b0;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            sclk_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            sclk_q   <= sclk_d;
        end
    end

    assign sdo  = {sh_q[1][COL_W-1], sh_q[0][COL_W-1]};
    assign sclk = sclk_q;
    // High during the final cycle of the last bit, so the owner can leave SHIFT on time.
    assign done = active_q && (div_q == DIV_LAST) && (bit_q == BIT_LAST);

endmodule

// File: rtl/rot_column_scanner.sv
// Read-side scanner: fetches the theta / theta+pi columns from the frame buffer,
// shifts them to both LED arms and latches them, queueing at most one new angle.
module rot_column_scanner #(
    parameter int ROTATIONAL_RES = rot_display_pkg::ROTATIONAL_RES,
    parameter int DISPLAY_RADIUS = rot_display_pkg::DISPLAY_RADIUS,
    parameter int DISPLAY_HEIGHT = rot_display_pkg::DISPLAY_HEIGHT,
    parameter int DATA_SIZE      = rot_display_pkg::DATA_SIZE,
    parameter int READ_LATENCY   = 2,
    parameter int SCLK_DIV       = 4,
    parameter int LATCH_CYCLES   = 2
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0]            theta_now,
    input  logic                                         theta_valid,
    input  logic                                         fb_busy,
    input  logic [1:0][DISPLAY_HEIGHT*DATA_SIZE-1:0]     fb_columns,
    input  logic [1:0][$clog2(DISPLAY_RADIUS)-1:0]       fb_radii,
    output logic [$clog2(ROTATIONAL_RES)-1:0]            theta_read,
    output logic [1:0]                                   led_sdo,
    output logic                                         led_sclk,
    output logic                                         led_latch,
    output logic [1:0][$clog2(DISPLAY_RADIUS)-1:0]       arm_radii,
    output logic                                         frame_done,
    output logic                                         busy,
    output logic [15:0]                                  overrun_count
);

    import rot_display_pkg::*;

    localparam int T_W      = $clog2(ROTATIONAL_RES);
    localparam int R_W      = $clog2(DISPLAY_RADIUS);
    localparam int COL_W    = DISPLAY_HEIGHT * DATA_SIZE;
    localparam int SETTLE_W = $clog2(READ_LATENCY + 2);
    localparam int LATCH_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(READ_LATENCY + 1);
    localparam logic [LATCH_W-1:0]  LATCH_LAST  = LATCH_W'(LATCH_CYCLES - 1);

    scanner_state_t          state_q;
    scanner_state_t          state_d;
    logic [T_W-1:0]          theta_read_q;
    logic [T_W-1:0]          theta_read_d;
    logic [SETTLE_W-1:0]     settle_q;
    logic [SETTLE_W-1:0]     settle_d;
    logic                    pend_q;
    logic                    pend_d;
    logic [T_W-1:0]          pend_theta_q;
    logic [T_W-1:0]          pend_theta_d;
    logic [15:0]             overrun_count_q;
    logic [15:0]             overrun_count_d;
    logic [1:0][R_W-1:0]     stage_radii_q;
    logic [1:0][R_W-1:0]     stage_radii_d;
    logic [1:0][R_W-1:0]     arm_radii_q;
    logic [1:0][R_W-1:0]     arm_radii_d;
    logic                    led_latch_q;
    logic                    led_latch_d;
    logic [LATCH_W-1:0]      latch_cnt_q;
    logic [LATCH_W-1:0]      latch_cnt_d;
    logic                    frame_done_q;
    logic                    frame_done_d;
    logic                    busy_q;
    logic                    busy_d;

    logic                    load_s;
    logic                    ser_done_s;
    logic                    latch_exit_s;
    logic                    hold_angle_s;

    column_serializer #(
        .COL_W    (COL_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_serializer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .load    (load_s),
        .columns (fb_columns),
        .sdo     (led_sdo),
        .sclk    (led_sclk),
        .done    (ser_done_s)
    );

    assign latch_exit_s = (state_q == LATCH) && (latch_cnt_q == LATCH_LAST);
    // Angles arriving while a frame is on the wire are queued; the exit cycle consumes its own.
    assign hold_angle_s = (state_q == SHIFT) || ((state_q == LATCH) && !latch_exit_s);

    // Scanner FSM, settle counter, pending-angle queue and radii staging.
    always_comb begin
        state_d         = state_q;
        theta_read_d    = theta_read_q;
        settle_d        = settle_q;
        pend_d          = pend_q;
        pend_theta_d    = pend_theta_q;
        overrun_count_d = overrun_count_q;
        stage_radii_d   = stage_radii_q;
        arm_radii_d     = arm_radii_q;
        led_latch_d     = 1'b0;
        latch_cnt_d     = latch_cnt_q;
        frame_done_d    = 1'b0;
        load_s          = 1'b0;

        if (hold_angle_s && theta_valid) begin
            pend_theta_d = theta_now;
            pend_d       = 1'b1;
            if (pend_q) begin
                overrun_count_d = sat_inc(overrun_count_q);
            end else begin
                overrun_count_d = overrun_count_q;
            end
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            IDLE: begin
                if (theta_valid) begin
                    theta_read_d = theta_now;
                    settle_d     = '0;
                    state_d      = REQUEST;
                end else begin
                    state_d = IDLE;
                end
            end
            REQUEST: begin
                if (theta_valid) begin
                    theta_read_d = theta_now;
                    settle_d     = '0;
                end else if (fb_busy) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_DONE) begin
                    load_s        = 1'b1;
                    stage_radii_d = fb_radii;
                    state_d       = SHIFT;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            SHIFT: begin
                if (ser_done_s) begin
                    state_d     = LATCH;
                    led_latch_d = 1'b1;
                    latch_cnt_d = '0;
                    arm_radii_d = stage_radii_q;
                end else begin
                    state_d = SHIFT;
                end
            end
            LATCH: begin
                if (latch_exit_s) begin
                    frame_done_d = 1'b1;
                    settle_d     = '0;
                    pend_d       = 1'b0;
                    if (theta_valid) begin
                        // A fresh angle beats a queued one; the queued angle counts as dropped.
                        theta_read_d = theta_now;
                        state_d      = REQUEST;
                        if (pend_q) begin
                            overrun_count_d = sat_inc(overrun_count_q);
                        end else begin
                            overrun_count_d = overrun_count_q;
                        end
                    end else if (pend_q) begin
                        theta_read_d = pend_theta_q;
                        state_d      = REQUEST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    led_latch_d = 1'b1;
                    latch_cnt_d = latch_cnt_q + LATCH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            theta_read_q    <= '0;
            settle_q        <= '0;
            pend_q          <= 1'b0;
            pend_theta_q    <= '0;
            overrun_count_q <= '0;
            stage_radii_q   <= '0;
            arm_radii_q     <= '0;
            led_latch_q     <= 1'b0;
            latch_cnt_q     <= '0;
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            theta_read_q    <= theta_read_d;
            settle_q        <= settle_d;
            pend_q          <= pend_d;
            pend_theta_q    <= pend_theta_d;
            overrun_count_q <= overrun_count_d;
            stage_radii_q   <= stage_radii_d;
            arm_radii_q     <= arm_radii_d;
            led_latch_q     <= led_latch_d;
            latch_cnt_q     <= latch_cnt_d;
            frame_done_q    <= frame_done_d;
            busy_q          <= busy_d;
        end
    end

    assign theta_read    = theta_read_q;
    assign led_latch     = led_latch_q;
    assign arm_radii     = arm_radii_q;
    assign frame_done    = frame_done_q;
    assign busy          = busy_q;
    assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_rot_column_scanner.sv
// Randomized self-checking bench for rot_column_scanner with a latency-2 frame buffer model.
module tb_rot_column_scanner;

    localparam int RES = 1024;
    localparam int RAD = 32;
    localparam int H   = 8;
    localparam int DS  = 1;
    localparam int RL  = 2;
    localparam int DIV = 2;
    localparam int LC  = 2;
    localparam int TW  = 10;
    localparam int RW  = 5;
    localparam int CW  = H * DS;
    // Cycles from the last request/busy edge to the first rising sclk sample.
    localparam int FIRST_RISE = RL + 2 + DIV / 2;

    logic                 clk = 1'b0;
    logic                 rst_in;
    logic [TW-1:0]        theta_now;
    logic                 theta_valid;
    logic                 fb_busy;
    logic [1:0][CW-1:0]   fb_columns;
    logic [1:0][RW-1:0]   fb_radii;
    logic [TW-1:0]        theta_read;
    logic [1:0]           led_sdo;
    logic                 led_sclk;
    logic                 led_latch;
    logic [1:0][RW-1:0]   arm_radii;
    logic                 frame_done;
    logic                 busy;
    logic [15:0]          overrun_count;

    always #5 clk = ~clk;

    rot_column_scanner #(
        .ROTATIONAL_RES (RES), .DISPLAY_RADIUS (RAD), .DISPLAY_HEIGHT (H),
        .DATA_SIZE (DS), .READ_LATENCY (RL), .SCLK_DIV (DIV), .LATCH_CYCLES (LC)
    ) dut (
        .clk_in (clk), .rst_in (rst_in), .theta_now (theta_now), .theta_valid (theta_valid),
        .fb_busy (fb_busy), .fb_columns (fb_columns), .fb_radii (fb_radii),
        .theta_read (theta_read), .led_sdo (led_sdo), .led_sclk (led_sclk),
        .led_latch (led_latch), .arm_radii (arm_radii), .frame_done (frame_done),
        .busy (busy), .overrun_count (overrun_count)
    );

    // Frame buffer model: two-stage read pipe whose outputs are zero while busy.
    logic [CW-1:0]      mem0 [RES];
    logic [CW-1:0]      mem1 [RES];
    logic [RW-1:0]      rad0 [RES];
    logic [RW-1:0]      rad1 [RES];
    logic [1:0][CW-1:0] p1_col, p2_col;
    logic [1:0][RW-1:0] p1_rad, p2_rad;

    always @(posedge clk) begin
        if (fb_busy) begin
            p1_col <= '0; p2_col <= '0; p1_rad <= '0; p2_rad <= '0;
        end else begin
            p1_col <= {mem1[theta_read], mem0[theta_read]};
            p1_rad <= {rad1[theta_read], rad0[theta_read]};
            p2_col <= p1_col;
            p2_rad <= p1_rad;
        end
    end
    assign fb_columns = p2_col;
    assign fb_radii   = p2_rad;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_rise, latch_len, done_cnt, sdo_glitch;
    bit s0[$];
    bit s1[$];
    logic [RW-1:0] lat_r0, lat_r1;
    logic prev_sclk = 1'b0;
    logic [1:0] prev_sdo = 2'b00;
    int ovr_model = 0;

    function automatic logic [CW-1:0] pack_bits(input bit q[$]);
        logic [CW-1:0] r = '0;
        for (int i = 0; i < q.size(); i++) r = {r[CW-2:0], q[i]};
        return r;
    endfunction

    task automatic clear_mon();
        s0.delete(); s1.delete();
        first_rise = -1; latch_len = 0; done_cnt = 0; sdo_glitch = 0;
    endtask

    // One clock: inputs applied at the posedge, outputs observed at the negedge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (led_sclk && !prev_sclk) begin
            if (s0.size() == 0) first_rise = cyc;
            s0.push_back(led_sdo[0]);
            s1.push_back(led_sdo[1]);
            if (led_sdo !== prev_sdo) sdo_glitch++;
        end
        if (led_latch) begin
            if (latch_len == 0) begin lat_r0 = arm_radii[0]; lat_r1 = arm_radii[1]; end
            latch_len++;
        end
        if (frame_done) done_cnt++;
        prev_sclk = led_sclk;
        prev_sdo  = led_sdo;
    endtask

    task automatic pulse(input logic [TW-1:0] t);
        theta_now = t; theta_valid = 1'b1;
        tick();
        theta_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin tick(); n++; end
        ok = (done_cnt != 0);
    endtask

    task automatic wait_bits(input int nb, output bit ok);
        int n = 0;
        while (s0.size() < nb && n < 100) begin tick(); n++; end
        ok = (s0.size() >= nb);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; theta_valid = 1'b0; fb_busy = 1'b0; theta_now = '0;
        repeat (3) tick();
        checks++; if (theta_read !== 10'd0) begin failures++; $display("FAIL reset_theta_read got=%0h exp=0", theta_read); end
        checks++; if (led_sdo !== 2'b00 || led_sclk !== 1'b0 || led_latch !== 1'b0) begin failures++; $display("FAIL reset_led got=%b%b%b exp=0000", led_sdo, led_sclk, led_latch); end
        checks++; if (arm_radii !== 10'd0 || frame_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_misc got=%0h/%b/%b exp=0/0/0", arm_radii, frame_done, busy); end
        checks++; if (overrun_count !== 16'd0) begin failures++; $display("FAIL reset_overrun got=%0h exp=0", overrun_count); end
        rst_in = 1'b0;
        tick();
        ovr_model = 0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        bit ok;
        int a;
        mem0[5] = 8'hA5; mem1[5] = 8'h3C; rad0[5] = 5'd7; rad1[5] = 5'd12;
        clear_mon();
        pulse(10'd5);
        a = cyc;
        checks++; if (theta_read !== 10'd5 || busy !== 1'b1) begin failures++; $display("FAIL basic_request got=%0d/%b exp=5/1", theta_read, busy); end
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no frame_done exp=frame_done"); end
        checks++; if (pack_bits(s0) !== 8'hA5 || s0.size() != CW) begin failures++; $display("FAIL basic_arm0 got=%0h(%0d bits) exp=a5", pack_bits(s0), s0.size()); end
        checks++; if (pack_bits(s1) !== 8'h3C) begin failures++; $display("FAIL basic_arm1 got=%0h exp=3c", pack_bits(s1)); end
        checks++; if (first_rise != a + FIRST_RISE) begin failures++; $display("FAIL basic_capture_time got=%0d exp=%0d", first_rise - a, FIRST_RISE); end
        checks++; if (latch_len != LC) begin failures++; $display("FAIL basic_latch_len got=%0d exp=%0d", latch_len, LC); end
        checks++; if (lat_r0 !== 5'd7 || lat_r1 !== 5'd12) begin failures++; $display("FAIL basic_radii got=%0d/%0d exp=7/12", lat_r0, lat_r1); end
        checks++; if (sdo_glitch != 0) begin failures++; $display("FAIL basic_sdo_stable got=%0d exp=0", sdo_glitch); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
        repeat (4) tick();
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_once got=%0d exp=1", done_cnt); end
    endtask

    // Random angle, random delay before an optional random-length busy burst.
    task automatic run_stall(input string name, input int delay, input int blen);
        bit ok;
        int last;
        logic [TW-1:0] t;
        t = TW'($urandom_range(0, RES - 1));
        clear_mon();
        pulse(t);
        last = cyc;
        repeat (delay) tick();
        if (blen > 0) begin
            fb_busy = 1'b1;
            repeat (blen) tick();
            last = cyc;
            fb_busy = 1'b0;
        end
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_timeout got=no frame_done exp=frame_done", name); end
        checks++; if (pack_bits(s0) !== mem0[t] || pack_bits(s1) !== mem1[t]) begin failures++; $display("FAIL %s_data got=%0h/%0h exp=%0h/%0h", name, pack_bits(s0), pack_bits(s1), mem0[t], mem1[t]); end
        checks++; if (first_rise != last + FIRST_RISE) begin failures++; $display("FAIL %s_capture_time got=%0d exp=%0d", name, first_rise - last, FIRST_RISE); end
        checks++; if (lat_r0 !== rad0[t] || lat_r1 !== rad1[t]) begin failures++; $display("FAIL %s_radii got=%0d/%0d exp=%0d/%0d", name, lat_r0, lat_r1, rad0[t], rad1[t]); end
    endtask

    task automatic test_busy_stall();
        run_stall("busy_stall", 1, 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) run_stall("random", $urandom_range(0, 2), $urandom_range(0, 4));
    endtask

    task automatic test_overrun();
        bit ok;
        bit pend = 1'b0;
        logic [TW-1:0] t0;
        t0 = TW'($urandom_range(100, 900));
        clear_mon();
        pulse(t0);
        wait_bits(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL overrun_shift_timeout got=%0d bits exp=2", s0.size()); end
        for (int v = 10; v <= 12; v++) begin
            pulse(TW'(v));
            if (pend) ovr_model++;
            pend = 1'b1;
        end
        wait_done(ok);
        checks++; if (pack_bits(s0) !== mem0[t0] || pack_bits(s1) !== mem1[t0]) begin failures++; $display("FAIL overrun_frame_intact got=%0h/%0h exp=%0h/%0h", pack_bits(s0), pack_bits(s1), mem0[t0], mem1[t0]); end
        checks++; if (theta_read !== 10'd12 || busy !== 1'b1) begin failures++; $display("FAIL overrun_next_request got=%0d/%b exp=12/1", theta_read, busy); end
        checks++; if (overrun_count !== 16'(ovr_model)) begin failures++; $display("FAIL overrun_count got=%0d exp=%0d", overrun_count, ovr_model); end
        clear_mon();
        wait_done(ok);
        checks++; if (!ok || pack_bits(s0) !== mem0[12] || pack_bits(s1) !== mem1[12]) begin failures++; $display("FAIL overrun_second_frame got=%0h/%0h exp=%0h/%0h", pack_bits(s0), pack_bits(s1), mem0[12], mem1[12]); end
    endtask

    task automatic test_rerequest();
        bit ok;
        clear_mon();
        pulse(10'd20);
        tick();
        pulse(10'd21);
        checks++; if (theta_read !== 10'd21) begin failures++; $display("FAIL rereq_theta got=%0d exp=21", theta_read); end
        wait_done(ok);
        checks++; if (!ok || pack_bits(s0) !== mem0[21] || pack_bits(s1) !== mem1[21]) begin failures++; $display("FAIL rereq_data got=%0h/%0h exp=%0h/%0h", pack_bits(s0), pack_bits(s1), mem0[21], mem1[21]); end
        checks++; if (overrun_count !== 16'(ovr_model)) begin failures++; $display("FAIL rereq_overrun got=%0d exp=%0d", overrun_count, ovr_model); end
        repeat (30) tick();
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin failures++; $display("FAIL rereq_single_frame got=%0d/%b exp=1/0", done_cnt, busy); end
    endtask

    task automatic test_midshift_reset();
        bit ok;
        logic [TW-1:0] t;
        clear_mon();
        pulse(TW'($urandom_range(0, RES - 1)));
        wait_bits(4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midreset_shift_timeout got=%0d bits exp=4", s0.size()); end
        rst_in = 1'b1;
        tick();
        ovr_model = 0;
        checks++; if (theta_read !== 10'd0 || led_sdo !== 2'b00 || led_sclk !== 1'b0 || led_latch !== 1'b0) begin failures++; $display("FAIL midreset_led got=%0h/%b/%b/%b exp=0/0/0/0", theta_read, led_sdo, led_sclk, led_latch); end
        checks++; if (arm_radii !== 10'd0 || frame_done !== 1'b0 || busy !== 1'b0 || overrun_count !== 16'd0) begin failures++; $display("FAIL midreset_misc got=%0h/%b/%b/%0h exp=0/0/0/0", arm_radii, frame_done, busy, overrun_count); end
        rst_in = 1'b0;
        tick();
        t = TW'($urandom_range(0, RES - 1));
        clear_mon();
        pulse(t);
        wait_done(ok);
        checks++; if (!ok || s0.size() != CW || pack_bits(s0) !== mem0[t] || pack_bits(s1) !== mem1[t]) begin failures++; $display("FAIL midreset_clean_frame got=%0h/%0h exp=%0h/%0h", pack_bits(s0), pack_bits(s1), mem0[t], mem1[t]); end
    endtask

    task automatic test_saturation();
        bit ok;
        force dut.overrun_count_q = 16'hFFF0;
        tick();
        release dut.overrun_count_q;
        ovr_model = 32'hFFF0;
        clear_mon();
        pulse(TW'($urandom_range(0, RES - 1)));
        for (int f = 0; f < 4; f++) begin
            wait_bits(1, ok);
            for (int k = 0; k < 10; k++) begin
                pulse(TW'($urandom_range(0, RES - 1)));
                if (k > 0) ovr_model = (ovr_model >= 32'hFFFF) ? 32'hFFFF : ovr_model + 1;
            end
            wait_done(ok);
            checks++; if (!ok || overrun_count !== 16'(ovr_model)) begin failures++; $display("FAIL saturation_frame%0d got=%0h exp=%0h", f, overrun_count, ovr_model); end
            clear_mon();
        end
        wait_done(ok);
        checks++; if (overrun_count !== 16'hFFFF || busy !== 1'b0) begin failures++; $display("FAIL saturation_hold got=%0h/%b exp=ffff/0", overrun_count, busy); end
    endtask

    initial begin
        for (int i = 0; i < RES; i++) begin
            mem0[i] = CW'($urandom_range(1, 255));
            mem1[i] = CW'($urandom_range(1, 255));
            rad0[i] = RW'($urandom_range(0, RAD - 1));
            rad1[i] = RW'($urandom_range(0, RAD - 1));
        end
        test_reset();
        test_basic();
        test_busy_stall();
        test_overrun();
        test_rerequest();
        test_random();
        test_midshift_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
